hvac_zone_arbiter: RTL and testbench
====================================

// Module: hvac_zone_arbiter
// PURPOSE
//  Shares one greenhouse HVAC actuator (heater + cooler) between N_ZONES zone
//  thermostat controllers. Each zone controller raises a heat or cool request.
//  This block grants the actuator to one zone at a time, round-robin, and
//  enforces a minimum run time, a fairness cap and an actuator dead time.
//  It sits between the per-zone temperature controllers and the actuator drivers.
// PARAMETERS
//  N_ZONES  4    number of requesting zones (2..8)
//  MIN_ON   16   minimum cycles a grant is held once issued (>=1)
//  MAX_ON   256  run cycles after which a waiting zone may preempt (>MIN_ON)
//  DEAD     8    cycles with actuator fully off between grants (>=1)
//  CNT_W    9    run/dead counter width; must hold MAX_ON and DEAD
// PORTS
//  clk       in   1        clock, all state updates on posedge
//  rst       in   1        reset, synchronous, active-high
//  heat_req  in   N_ZONES  per-zone heat request (level)
//  cool_req  in   N_ZONES  per-zone cool request (level)
//  grant     out  N_ZONES  one-hot granted zone, registered; all-zero when none
//  zone_id   out  3        index of granted zone, registered; 0 when none
//  heat_on   out  1        heater drive, registered
//  cool_on   out  1        cooler drive, registered
//  busy      out  1        1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE; grant=0, zone_id=0, heat_on=0, cool_on=0, busy=0;
//    rr pointer=0, counters=0. Reset mid-RUN/DEAD drops outputs at that edge;
//    no dead time is applied across reset.
//  - Valid request of zone i: heat_req[i] XOR cool_req[i]. Both high = conflict,
//    treated as no request. heat_on and cool_on are never both 1.
//  - States: IDLE, RUN, DEAD.
//  - IDLE: if any valid request, select first valid zone searching upward from
//    rr pointer with wrap (N_ZONES-1 -> 0). At that edge: state<=RUN, grant/
//    zone_id set, mode latched (heat if heat_req, else cool), heat_on/cool_on
//    set, run_cnt<=0. Request high in cycle t -> outputs high after edge t+1.
//  - RUN: run_cnt increments each cycle, saturating at MAX_ON-1. Release when
//    (a) run_cnt>=MIN_ON-1 and granted zone no longer validly requests the
//    latched mode (drop, conflict, or switch to opposite mode), or
//    (b) run_cnt==MAX_ON-1 and any other zone has a valid request.
//    With no other requester the grant persists indefinitely past MAX_ON.
//    Request drop before MIN_ON is ignored; actuator stays on until MIN_ON.
//  - Release edge: state<=DEAD, grant=0, zone_id=0, heat_on=cool_on=0,
//    dead_cnt<=0, rr pointer <= granted index+1 (wrapping).
//  - DEAD: dead_cnt counts DEAD cycles with outputs off, then state<=IDLE.
//    IDLE arbitrates on its first cycle, so the off gap between two grants is
//    exactly DEAD+1 cycles.
//  - Requests seen during RUN/DEAD are not latched; only levels in IDLE count.
//  - Same zone may be re-granted after DEAD if it is the only requester.
// TESTING
//  1 Reset: rst=1 two cycles with all requests high -> grant=0, heat_on=0,
//    cool_on=0, busy=0 throughout; first grant 2 edges after rst falls.
//  2 Single heat: heat_req=4'b0010 at t0, drop at t0+3 -> grant=4'b0010,
//    zone_id=1, heat_on=1 from t0+1 for exactly MIN_ON=16 cycles, then 9-cycle off.
//  3 Round-robin: cool_req=4'b1111 held, MAX_ON=256 -> grants zone 0,1,2,3,0
//    each 256 cycles, separated by 9 off cycles; cool_on only.
//  4 Conflict: heat_req=cool_req=4'b0001 -> no grant; add cool_req[2]=1 ->
//    zone 2 granted, cool_on=1, heat_on=0.
//  5 Mode flip: zone 3 heating, after 20 cycles switch to cool_req only ->
//    heat_on falls next edge, DEAD 8, then zone 3 granted with cool_on=1.
//  6 Reset mid-RUN: assert rst at run_cnt=5 -> outputs 0 after that edge,
//    busy=0, rr pointer=0, zone 0 wins on next request set 4'b1001.

Source files
------------

// File: rtl/hvac_zone_if.sv
// hvac_zone_if
// Bundles the zone-request / actuator-grant signals of the HVAC zone arbiter.
//   heat_req, cool_req : per-zone level requests from the zone thermostat controllers
//   grant              : one-hot granted zone, all-zero when the actuator is free
//   zone_id            : index of the granted zone, 0 when none
//   heat_on, cool_on   : actuator drives, never both high
//   busy               : arbiter is not idle (running or in dead time)
// Modports:
//   master : the zone-controller side, drives requests and observes the grant
//   slave  : the arbiter side, consumes requests and drives grant/actuator
interface hvac_zone_if #(
    parameter int N_ZONES = 4
);
    logic [N_ZONES-1:0] heat_req;
    logic [N_ZONES-1:0] cool_req;
    logic [N_ZONES-1:0] grant;
    logic [2:0]         zone_id;
    logic               heat_on;
    logic               cool_on;
    logic               busy;

    modport master (
        output heat_req, cool_req,
        input  grant, zone_id, heat_on, cool_on, busy
    );

    modport slave (
        input  heat_req, cool_req,
        output grant, zone_id, heat_on, cool_on, busy
    );
endinterface

// File: rtl/hvac_zone_arbiter.sv
// hvac_zone_arbiter
// Shares one greenhouse heater/cooler actuator between N_ZONES zone thermostats.
// One zone holds the actuator at a time, chosen round-robin. A grant is held for
// at least MIN_ON cycles; after MAX_ON cycles of running, another waiting zone
// may take over. Every hand-over passes through DEAD cycles of fully-off actuator
// plus one arbitration cycle.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-high reset
//   bus  : hvac_zone_if.slave -- requests in; grant, zone_id, heat_on, cool_on,
//          busy out (all registered; busy decodes the registered state)
module hvac_zone_arbiter #(
    parameter int N_ZONES = 4,
    parameter int MIN_ON  = 16,
    parameter int MAX_ON  = 256,
    parameter int DEAD    = 8,
    parameter int CNT_W   = 9
) (
    input  logic       clk,
    input  logic       rst,
    hvac_zone_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD - 1);
    localparam logic [2:0]       LAST_ZONE = 3'(N_ZONES - 1);

    state_t             state_q, state_d;
    logic [2:0]         rr_q, rr_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0]   dead_cnt_q, dead_cnt_d;
    logic [N_ZONES-1:0] grant_q, grant_d;
    logic [2:0]         zone_id_q, zone_id_d;
    logic               heat_on_q, heat_on_d;
    logic               cool_on_q, cool_on_d;
    logic               mode_heat_q, mode_heat_d;

    // A zone asking for heat and cool at once is in conflict and counts as idle.
    logic [N_ZONES-1:0] valid;
    assign valid = bus.heat_req ^ bus.cool_req;

    // Round-robin pick: lowest valid index at or above rr_q, otherwise the lowest
    // valid index overall (the wrap-around case). The loop runs downward so the
    // last hit is the lowest index.
    logic               hi_found;
    logic [2:0]         hi_idx;
    logic [2:0]         any_idx;
    logic [2:0]         pick_idx;
    logic [N_ZONES-1:0] pick_onehot;
    logic               pick_heat;

    always_comb begin
        hi_found = 1'b0;
        hi_idx   = 3'd0;
        any_idx  = 3'd0;
        for (int i = N_ZONES - 1; i >= 0; i--) begin
            if (valid[i]) begin
                any_idx = 3'(i);
                if (3'(i) >= rr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = 3'(i);
                end
            end
        end
        pick_idx    = hi_found ? hi_idx : any_idx;
        pick_onehot = N_ZONES'(1) << pick_idx;
        pick_heat   = |(pick_onehot & bus.heat_req);
    end

    // The granted zone keeps the actuator only while it still cleanly asks for
    // the mode latched at grant time; a flip to the other mode is a drop.
    logic still_req;
    logic others_waiting;
    logic release_now;

    always_comb begin
        if (mode_heat_q) begin
            still_req = |(grant_q & bus.heat_req & ~bus.cool_req);
        end else begin
            still_req = |(grant_q & bus.cool_req & ~bus.heat_req);
        end
        others_waiting = |(valid & ~grant_q);
        release_now    = ((run_cnt_q >= MIN_LAST) && !still_req) ||
                         ((run_cnt_q == MAX_LAST) && others_waiting);
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        run_cnt_d   = run_cnt_q;
        dead_cnt_d  = dead_cnt_q;
        grant_d     = grant_q;
        zone_id_d   = zone_id_q;
        heat_on_d   = heat_on_q;
        cool_on_d   = cool_on_q;
        mode_heat_d = mode_heat_q;

        case (state_q)
            ST_IDLE: begin
                if (|valid) begin
                    state_d     = ST_RUN;
                    grant_d     = pick_onehot;
                    zone_id_d   = pick_idx;
                    mode_heat_d = pick_heat;
                    heat_on_d   = pick_heat;
                    cool_on_d   = !pick_heat;
                    run_cnt_d   = '0;
                end
            end

            ST_RUN: begin
                if (release_now) begin
                    state_d    = ST_DEAD;
                    grant_d    = '0;
                    zone_id_d  = 3'd0;
                    heat_on_d  = 1'b0;
                    cool_on_d  = 1'b0;
                    dead_cnt_d = '0;
                    rr_d       = (zone_id_q == LAST_ZONE) ? 3'd0 : zone_id_q + 3'd1;
                end else if (run_cnt_q != MAX_LAST) begin
                    // Saturate so a lone requester can run indefinitely while
                    // the fairness check stays armed.
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end

            ST_DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Reset clears everything at once: no dead time is enforced across reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_q        <= 3'd0;
            run_cnt_q   <= '0;
            dead_cnt_q  <= '0;
            grant_q     <= '0;
            zone_id_q   <= 3'd0;
            heat_on_q   <= 1'b0;
            cool_on_q   <= 1'b0;
            mode_heat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            run_cnt_q   <= run_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            grant_q     <= grant_d;
            zone_id_q   <= zone_id_d;
            heat_on_q   <= heat_on_d;
            cool_on_q   <= cool_on_d;
            mode_heat_q <= mode_heat_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.zone_id = zone_id_q;
    assign bus.heat_on = heat_on_q;
    assign bus.cool_on = cool_on_q;
    assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hvac_zone_arbiter.sv
// tb_hvac_zone_arbiter
// Bench for hvac_zone_arbiter (N_ZONES=4, MIN_ON=16, MAX_ON=256, DEAD=8).
// Each test pushes the grants it expects (zone, mode, length, off gap before
// the grant) into a queue; a monitor pops one record whenever a grant ends and
// compares it with what it measured. Tests also check key cycles inline.
module tb_hvac_zone_arbiter;

    logic clk;
    logic rst;

    hvac_zone_if #(.N_ZONES(4)) bus ();

    hvac_zone_arbiter #(
        .N_ZONES(4),
        .MIN_ON (16),
        .MAX_ON (256),
        .DEAD   (8),
        .CNT_W  (9)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int zone;
        bit heat;
        int len;
        int gap;   // -1: gap not checked
    } rec_t;

    rec_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   ends  = 0;

    // ---------------- monitor ----------------
    logic [3:0] prev_grant = 4'b0;
    int         cur_zone, cur_len, cur_gap, off_cnt;
    bit         cur_heat, cur_cool, gap_valid = 1'b0, last_edge_rst = 1'b0;

    always @(posedge clk) last_edge_rst = rst;

    always @(negedge clk) begin
        int gz;
        rec_t r;
        total++;
        if (bus.heat_on === 1'b1 && bus.cool_on === 1'b1) begin
            bad++;
            $display("FAIL both_on got heat_on=1 cool_on=1 want not both");
        end
        if (bus.grant !== 4'b0) begin
            gz = -1;
            for (int i = 0; i < 4; i++) if (bus.grant[i]) gz = i;
            total++;
            if (!$onehot(bus.grant) || bus.zone_id !== 3'(gz) || bus.busy !== 1'b1) begin
                bad++;
                $display("FAIL grant_consistency got grant=%b zone_id=%0d busy=%b want onehot, zone_id=%0d, busy=1",
                         bus.grant, bus.zone_id, bus.busy, gz);
            end
        end
        if (bus.grant !== 4'b0 && prev_grant === 4'b0) begin
            cur_zone = -1;
            for (int i = 0; i < 4; i++) if (bus.grant[i]) cur_zone = i;
            cur_heat = bus.heat_on;
            cur_cool = bus.cool_on;
            cur_len  = 1;
            cur_gap  = gap_valid ? off_cnt : -1;
        end else if (bus.grant !== 4'b0) begin
            cur_len++;
            total++;
            if (bus.grant !== prev_grant || bus.heat_on !== cur_heat || bus.cool_on !== cur_cool) begin
                bad++;
                $display("FAIL grant_stable got grant=%b heat=%b cool=%b want grant=%b heat=%b cool=%b",
                         bus.grant, bus.heat_on, bus.cool_on, prev_grant, cur_heat, cur_cool);
            end
        end else if (prev_grant !== 4'b0) begin
            ends++;
            off_cnt   = 1;
            gap_valid = !last_edge_rst;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_grant got zone=%0d len=%0d want no grant", cur_zone, cur_len);
            end else begin
                r = sb.pop_front();
                if (cur_zone != r.zone || cur_heat != r.heat || cur_cool != !r.heat ||
                    cur_len != r.len || (r.gap >= 0 && cur_gap != r.gap)) begin
                    bad++;
                    $display("FAIL grant_record got zone=%0d heat=%b cool=%b len=%0d gap=%0d want zone=%0d heat=%b len=%0d gap=%0d",
                             cur_zone, cur_heat, cur_cool, cur_len, cur_gap, r.zone, r.heat, r.len, r.gap);
                end
            end
        end else begin
            off_cnt++;
            if (last_edge_rst) gap_valid = 1'b0;
        end
        prev_grant = bus.grant;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int zone, input bit heat, input int len, input int gap);
        rec_t r;
        r.zone = zone; r.heat = heat; r.len = len; r.gap = gap;
        sb.push_back(r);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.busy === 1'b0 && bus.grant === 4'b0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_idle got busy=%b want 0 within %0d cycles", bus.busy, budget);
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.heat_req = 4'b1111;
        bus.cool_req = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (bus.grant !== 4'b0 || bus.heat_on !== 1'b0 || bus.cool_on !== 1'b0 || bus.busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs got grant=%b heat=%b cool=%b busy=%b want 0 0 0 0",
                         bus.grant, bus.heat_on, bus.cool_on, bus.busy);
            end
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0) begin
            bad++;
            $display("FAIL reset_release_early got grant=%b want 0000", bus.grant);
        end
        push(0, 1'b1, 16, -1);
        tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0001 || bus.heat_on !== 1'b1 || bus.cool_on !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_grant got grant=%b heat=%b cool=%b want 0001 1 0",
                     bus.grant, bus.heat_on, bus.cool_on);
        end
        bus.heat_req = 4'b0000;
        wait_idle(100);
    endtask

    task automatic test_single_heat();
        tick();
        push(1, 1'b1, 16, -1);
        bus.heat_req = 4'b0010;
        tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0010 || bus.zone_id !== 3'd1 || bus.heat_on !== 1'b1) begin
            bad++;
            $display("FAIL single_start got grant=%b zone_id=%0d heat=%b want 0010 1 1",
                     bus.grant, bus.zone_id, bus.heat_on);
        end
        tick();
        tick();
        bus.heat_req = 4'b0000;
        repeat (13) tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0010 || bus.heat_on !== 1'b1) begin
            bad++;
            $display("FAIL single_min_on got grant=%b heat=%b want 0010 1", bus.grant, bus.heat_on);
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0 || bus.heat_on !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL single_release got grant=%b heat=%b busy=%b want 0000 0 1",
                     bus.grant, bus.heat_on, bus.busy);
        end
        repeat (7) tick();
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL dead_last got busy=%b want 1", bus.busy);
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL dead_end got busy=%b want 0", bus.busy);
        end
    endtask

    task automatic test_round_robin();
        int target;
        do_reset();
        push(0, 1'b0, 256, -1);
        push(1, 1'b0, 256, 9);
        push(2, 1'b0, 256, 9);
        push(3, 1'b0, 256, 9);
        push(0, 1'b0, 256, 9);
        target = ends + 5;
        bus.heat_req = 4'b0000;
        bus.cool_req = 4'b1111;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (ends >= target) break;
        end
        total++;
        if (ends < target) begin
            bad++;
            $display("FAIL rr_timeout got ends=%0d want %0d", ends, target);
        end
        bus.cool_req = 4'b0000;
        wait_idle(100);
    endtask

    task automatic test_conflict();
        tick();
        bus.heat_req = 4'b0001;
        bus.cool_req = 4'b0001;
        repeat (4) tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL conflict_idle got grant=%b busy=%b want 0000 0", bus.grant, bus.busy);
        end
        tick();
        push(2, 1'b0, 16, -1);
        bus.cool_req = 4'b0101;
        tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0100 || bus.cool_on !== 1'b1 || bus.heat_on !== 1'b0) begin
            bad++;
            $display("FAIL conflict_grant got grant=%b cool=%b heat=%b want 0100 1 0",
                     bus.grant, bus.cool_on, bus.heat_on);
        end
        bus.heat_req = 4'b0000;
        bus.cool_req = 4'b0000;
        wait_idle(100);
    endtask

    task automatic test_mode_flip();
        tick();
        push(3, 1'b1, 20, -1);
        push(3, 1'b0, 16, 9);
        bus.heat_req = 4'b1000;
        tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b1000 || bus.heat_on !== 1'b1) begin
            bad++;
            $display("FAIL flip_heat got grant=%b heat=%b want 1000 1", bus.grant, bus.heat_on);
        end
        repeat (19) tick();
        bus.heat_req = 4'b0000;
        bus.cool_req = 4'b1000;
        tick();
        @(negedge clk);
        total++;
        if (bus.heat_on !== 1'b0 || bus.grant !== 4'b0) begin
            bad++;
            $display("FAIL flip_release got heat=%b grant=%b want 0 0000", bus.heat_on, bus.grant);
        end
        repeat (9) tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b1000 || bus.cool_on !== 1'b1 || bus.heat_on !== 1'b0) begin
            bad++;
            $display("FAIL flip_cool got grant=%b cool=%b heat=%b want 1000 1 0",
                     bus.grant, bus.cool_on, bus.heat_on);
        end
        bus.cool_req = 4'b0000;
        wait_idle(100);
    endtask

    task automatic test_reset_mid_run();
        tick();
        push(2, 1'b1, 6, -1);
        push(0, 1'b1, 16, -1);
        bus.heat_req = 4'b0100;
        tick();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.heat_req = 4'b1001;
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0 || bus.busy !== 1'b0 || bus.heat_on !== 1'b0) begin
            bad++;
            $display("FAIL midrun_reset got grant=%b busy=%b heat=%b want 0000 0 0",
                     bus.grant, bus.busy, bus.heat_on);
        end
        tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0001 || bus.zone_id !== 3'd0) begin
            bad++;
            $display("FAIL midrun_rr got grant=%b zone_id=%0d want 0001 0", bus.grant, bus.zone_id);
        end
        bus.heat_req = 4'b0000;
        wait_idle(100);
    endtask

    task automatic test_max_on();
        tick();
        push(0, 1'b1, 300, -1);
        push(1, 1'b1, 16, 9);
        bus.heat_req = 4'b0001;
        tick();
        repeat (299) tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0001) begin
            bad++;
            $display("FAIL lone_past_max got grant=%b want 0001", bus.grant);
        end
        bus.heat_req = 4'b0011;
        repeat (10) tick();
        @(negedge clk);
        total++;
        if (bus.grant !== 4'b0010 || bus.heat_on !== 1'b1) begin
            bad++;
            $display("FAIL preempt_grant got grant=%b heat=%b want 0010 1", bus.grant, bus.heat_on);
        end
        bus.heat_req = 4'b0000;
        wait_idle(100);
    endtask

    initial begin
        rst = 1'b1;
        bus.heat_req = 4'b0000;
        bus.cool_req = 4'b0000;
        test_reset();
        test_single_heat();
        test_round_robin();
        test_conflict();
        test_mode_flip();
        test_reset_mid_run();
        test_max_on();
        repeat (3) @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_grants got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
